// File: rtl/parity_checker_rx_pkg.sv
// parity_checker_rx_pkg
// Shared definitions for the parity-checking serial receiver:
//   rx_state_e    receiver FSM states
//   LED_SEG_OFF   segment level for a blank (unlit) display
//   OK_CODE_DEF   default segment pattern for a good frame
//   ERR_CODE_DEF  default segment pattern for a bad frame
//   LED_AN_SEL    fixed anode selection
package parity_checker_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  // Segments are active-low: a blank display is all ones.
  localparam logic       LED_SEG_OFF  = 1'b1;
  localparam logic [7:0] OK_CODE_DEF  = 8'b00000011;
  localparam logic [7:0] ERR_CODE_DEF = 8'b00110001;
  localparam logic [3:0] LED_AN_SEL   = 4'b1101;

endpackage

// File: rtl/parity_checker_rx_bit_timer.sv
// bit_timer
// Sample-timing counter for the serial receiver.
//   clk    clock, rising edge
//   rst    synchronous active-high reset, clears the count
//   load   restart the count from zero (takes priority over count)
//   count  advance the count this cycle
//   mid    strobe on the last cycle of a half bit (while counting)
//   full   strobe on the last cycle of a full bit (while counting);
//          the count wraps to zero after it
module bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count,
  output logic mid,
  output logic full
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);

  logic [TW-1:0] cnt_q;

  always_comb begin
    mid  = count && (cnt_q == TW'(CLKS_PER_BIT / 2 - 1));
    full = count && (cnt_q == TW'(CLKS_PER_BIT - 1));
  end

  always_ff @(posedge clk) begin
    if (rst || load) begin
      cnt_q <= '0;
    end else if (count) begin
      cnt_q <= full ? '0 : cnt_q + TW'(1);
    end
  end

endmodule

// File: rtl/parity_checker_rx.sv
// parity_checker_rx
// Serial receiver (start, N_DATA data bits LSB first, parity, stop) that
// reports parity and framing errors and drives a segment display.
// Optional build macro: PARITY_ODD_EN selects odd parity (default even).
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset
//   rx_i       asynchronous serial line, idle high
//   data_o     last received word
//   valid_o    one-cycle pulse per completed frame
//   par_err_o  parity mismatch of last frame (held)
//   frm_err_o  stop bit low in last frame (held)
//   led_o      segment pattern: blank, OK_CODE or ERR_CODE
//   led_an_o   anode select (constant)
module parity_checker_rx
  import parity_checker_rx_pkg::*;
#(
  parameter int unsigned        N_DATA       = 8,
  parameter int unsigned        CLKS_PER_BIT = 16,
  parameter int unsigned        N_LED        = 8,
  parameter int unsigned        N_LED_AN     = 4,
  parameter logic [N_LED-1:0]   OK_CODE      = N_LED'(OK_CODE_DEF),
  parameter logic [N_LED-1:0]   ERR_CODE     = N_LED'(ERR_CODE_DEF)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                rx_i,
  output logic [N_DATA-1:0]   data_o,
  output logic                valid_o,
  output logic                par_err_o,
  output logic                frm_err_o,
  output logic [N_LED-1:0]    led_o,
  output logic [N_LED_AN-1:0] led_an_o
);

  localparam int unsigned BCW = $clog2(N_DATA + 1);

  rx_state_e         state_q, state_d;
  logic              rx_meta, rx_s;
  logic [BCW-1:0]    bit_cnt_q;
  logic [N_DATA-1:0] shift_q;
  logic              par_bit_q;
  logic              armed_q;

  logic timer_load, timer_en, tick_mid, tick_full;
  logic sample_data, sample_par, frame_done;
  logic par_exp, par_bad;

  assign led_an_o = N_LED_AN'(LED_AN_SEL);

  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk   (clk_i),
    .rst   (rst_i),
    .load  (timer_load),
    .count (timer_en),
    .mid   (tick_mid),
    .full  (tick_full)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    timer_load  = 1'b0;
    timer_en    = 1'b0;
    sample_data = 1'b0;
    sample_par  = 1'b0;
    frame_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_load = 1'b1;
        if (!rx_s && armed_q) state_d = ST_START;
      end
      ST_START: begin
        timer_en = 1'b1;
        // Restart the timer at mid-start so every later full-bit strobe
        // lands in the middle of a bit.
        if (tick_mid) begin
          timer_load = 1'b1;
          state_d    = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        timer_en = 1'b1;
        if (tick_full) begin
          sample_data = 1'b1;
          if (bit_cnt_q == BCW'(N_DATA - 1)) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        timer_en = 1'b1;
        if (tick_full) begin
          sample_par = 1'b1;
          state_d    = ST_STOP;
        end
      end
      ST_STOP: begin
        timer_en = 1'b1;
        if (tick_full) begin
          frame_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef PARITY_ODD_EN
  assign par_exp = ~(^shift_q);
`else
  assign par_exp = ^shift_q;
`endif
  assign par_bad = (par_bit_q != par_exp);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      armed_q   <= 1'b1;
      data_o    <= '0;
      valid_o   <= 1'b0;
      par_err_o <= 1'b0;
      frm_err_o <= 1'b0;
      led_o     <= {N_LED{LED_SEG_OFF}};
    end else begin
      valid_o <= frame_done;
      if (state_q == ST_IDLE)  bit_cnt_q <= '0;
      else if (sample_data)    bit_cnt_q <= bit_cnt_q + BCW'(1);
      if (sample_data) shift_q   <= {rx_s, shift_q[N_DATA-1:1]};
      if (sample_par)  par_bit_q <= rx_s;
      // A low stop bit disarms the start detector until the line has
      // been seen high again, so a stuck-low line cannot retrigger.
      if (frame_done && !rx_s) armed_q <= 1'b0;
      else if (rx_s)           armed_q <= 1'b1;
      if (frame_done) begin
        data_o    <= shift_q;
        par_err_o <= par_bad;
        frm_err_o <= !rx_s;
        led_o     <= (par_bad || !rx_s) ? ERR_CODE : OK_CODE;
      end
    end
  end

endmodule

// File: tb/tb_parity_checker_rx.sv
module tb_parity_checker_rx;

  localparam int unsigned CPB = 16;
  localparam int unsigned ND  = 8;
  localparam logic [7:0]  OK  = 8'b00000011;
  localparam logic [7:0]  ERR = 8'b00110001;
  // 2 synchronizer cycles plus the frame latency measured from rx_s.
  localparam int unsigned LAT = 2 + CPB / 2 + (ND + 2) * CPB + 1;
`ifdef PARITY_ODD_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif

  typedef struct {
    int unsigned cyc;
    logic [7:0]  data;
    logic        perr;
    logic        ferr;
    logic [7:0]  led;
  } obs_t;

  typedef struct {
    int unsigned start;
    logic [7:0]  data;
    logic        perr;
    logic        ferr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data_o;
  logic       valid_o, par_err_o, frm_err_o;
  logic [7:0] led_o;
  logic [3:0] led_an_o;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;

  obs_t mon_q[$];
  exp_t exp_q[$];
  logic prev_valid = 1'b0;

  logic [7:0] m_data;
  logic       m_perr, m_ferr;
  logic [7:0] m_led;

  parity_checker_rx #(
    .N_DATA       (ND),
    .CLKS_PER_BIT (CPB),
    .N_LED        (8),
    .N_LED_AN     (4)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .rx_i      (rx),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .par_err_o (par_err_o),
    .frm_err_o (frm_err_o),
    .led_o     (led_o),
    .led_an_o  (led_an_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (prev_valid) check("valid_width", {31'd0, valid_o}, 32'd0);
    if (valid_o) mon_q.push_back('{cyc, data_o, par_err_o, frm_err_o, led_o});
    prev_valid <= valid_o;
  end

  task automatic drive_bit(input logic lvl, input int unsigned gpos, output int unsigned t0);
    for (int unsigned i = 0; i < CPB; i++) begin
      @(negedge clk);
      if (i == 0) t0 = cyc;
      rx = (gpos != 0 && i == gpos) ? ~lvl : lvl;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit, input bit glitch);
    exp_t        e;
    int unsigned t, gp;
    drive_bit(1'b0, 0, e.start);
    for (int unsigned j = 0; j < ND; j++) begin
      gp = glitch ? (($urandom_range(0, 1) == 0) ? 2 : 12) : 0;
      drive_bit(d[j], gp, t);
    end
    drive_bit(pbit, 0, t);
    drive_bit(sbit, 0, t);
    e.data = d;
    e.perr = (pbit != ((^d) ^ ODD));
    e.ferr = !sbit;
    exp_q.push_back(e);
  endtask

  task automatic hold_line(input logic lvl, input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      rx = lvl;
    end
  endtask

  task automatic expect_frames(input int unsigned n);
    obs_t        o;
    exp_t        e;
    int unsigned w;
    for (int unsigned k = 0; k < n; k++) begin
      w = 0;
      while (mon_q.size() == 0 && w < 400) begin
        @(posedge clk);
        #2;
        w++;
      end
      e = exp_q.pop_front();
      if (mon_q.size() == 0) begin
        check("pulse_timeout", 32'd0, 32'd1);
      end else begin
        o = mon_q.pop_front();
        check("latency", o.cyc - e.start, LAT);
        check("data", {24'd0, o.data}, {24'd0, e.data});
        check("par_err", {31'd0, o.perr}, {31'd0, e.perr});
        check("frm_err", {31'd0, o.ferr}, {31'd0, e.ferr});
        check("led", {24'd0, o.led}, {24'd0, (e.perr || e.ferr) ? ERR : OK});
        m_data = e.data;
        m_perr = e.perr;
        m_ferr = e.ferr;
        m_led  = (e.perr || e.ferr) ? ERR : OK;
      end
    end
    check("extra_pulse", mon_q.size(), 32'd0);
  endtask

  task automatic check_hold(input string tag);
    @(negedge clk);
    check({tag, "_data"}, {24'd0, data_o}, {24'd0, m_data});
    check({tag, "_perr"}, {31'd0, par_err_o}, {31'd0, m_perr});
    check({tag, "_ferr"}, {31'd0, frm_err_o}, {31'd0, m_ferr});
    check({tag, "_led"}, {24'd0, led_o}, {24'd0, m_led});
    check({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
    check({tag, "_nopulse"}, mon_q.size(), 32'd0);
  endtask

  task automatic model_reset();
    m_data = 8'h00;
    m_perr = 1'b0;
    m_ferr = 1'b0;
    m_led  = 8'hFF;
  endtask

  initial begin
    logic [7:0]  d;
    logic        good, pbit, sbit;
    int unsigned t;

    rst = 1'b1;
    rx  = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_an", {28'd0, led_an_o}, 32'hD);
    check_hold("rst");

    // Good frame, then a wrong-parity frame.
    send_frame(8'h55, 1'b0, 1'b1, 1'b0);
    expect_frames(1);
    hold_line(1'b1, 5);
    send_frame(8'h07, 1'b0, 1'b1, 1'b0);
    expect_frames(1);
    hold_line(1'b1, 5);

    // False start: short low pulse, outputs must stay put.
    hold_line(1'b0, 4);
    hold_line(1'b1, 40);
    check_hold("false_start");
    send_frame(8'h96, ^8'h96 ^ ODD, 1'b1, 1'b0);
    expect_frames(1);
    hold_line(1'b1, 3);

    // Framing error, then a held-low line must not start a new frame.
    send_frame(8'hA3, ^8'hA3 ^ ODD, 1'b0, 1'b0);
    expect_frames(1);
    hold_line(1'b0, 300);
    check_hold("no_rearm");
    hold_line(1'b1, 20);
    send_frame(8'h5A, ^8'h5A ^ ODD, 1'b1, 1'b0);
    expect_frames(1);
    hold_line(1'b1, 3);

    // Reset in the middle of data bit 4.
    d = 8'hC9;
    drive_bit(1'b0, 0, t);
    for (int unsigned j = 0; j < 4; j++) drive_bit(d[j], 0, t);
    hold_line(d[4], 8);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    model_reset();
    hold_line(1'b1, 200);
    check_hold("mid_reset");
    send_frame(8'h3C, ^8'h3C ^ ODD, 1'b1, 1'b0);
    expect_frames(1);

    // Back-to-back frames with no idle gap.
    send_frame(8'h01, ^8'h01 ^ ODD, 1'b1, 1'b0);
    send_frame(8'hFF, ^8'hFF ^ ODD, 1'b1, 1'b0);
    expect_frames(2);

    // Randomized frames with mid-bit glitches and random errors.
    for (int unsigned n = 0; n < 20; n++) begin
      hold_line(1'b1, $urandom_range(1, 6));
      d    = 8'($urandom);
      good = (^d) ^ ODD;
      pbit = ($urandom_range(0, 3) == 0) ? ~good : good;
      sbit = ($urandom_range(0, 4) != 0);
      send_frame(d, pbit, sbit, 1'b1);
      expect_frames(1);
    end
    hold_line(1'b1, 20);
    check_hold("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parity_checker_rx.md
PARITY_CHECKER_RX -- requirements
Module: parity_checker_rx

Interface
REQ-001 SHALL have parameter N_DATA, default 8, data bits per frame.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; even, >=4.
REQ-003 SHALL have parameter N_LED, default 8, display segment count.
REQ-004 SHALL have parameter N_LED_AN, default 4, display anode count.
REQ-005 SHALL have parameter OK_CODE, default 8'b00000011, segment pattern for a good frame.
REQ-006 SHALL have parameter ERR_CODE, default 8'b00110001, segment pattern for a bad frame.
REQ-007 SHALL have port clk_i, input, 1, single clock; all logic on its rising edge.
REQ-008 SHALL have port rst_i, input, 1, reset, synchronous, active-high.
REQ-009 SHALL have port rx_i, input, 1, asynchronous serial line, idle high.
REQ-010 SHALL have port data_o, output, N_DATA, last received word, LSB first on line.
REQ-011 SHALL have port valid_o, output, 1, one-cycle pulse per completed frame.
REQ-012 SHALL have port par_err_o, output, 1, parity mismatch of last frame, held.
REQ-013 SHALL have port frm_err_o, output, 1, stop bit low in last frame, held.
REQ-014 SHALL have port led_o, output, N_LED, segment pattern.
REQ-015 SHALL have port led_an_o, output, N_LED_AN, anode select, constant 4'b1101.

Function
REQ-016 SHALL pass rx_i through a 2-flop synchronizer; all timing below is relative to the synchronized signal (rx_s).
REQ-017 SHALL implement FSM IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
REQ-018 IDLE: SHALL leave on the first cycle rx_s is low; bit counter and cycle counter cleared.
REQ-019 START: SHALL sample rx_s after CLKS_PER_BIT/2 cycles; if high (false start), return to IDLE with no outputs changed.
REQ-020 DATA: SHALL sample every CLKS_PER_BIT cycles, N_DATA samples, shifting LSB first; then go to PARITY.
REQ-021 PARITY: SHALL sample one bit after CLKS_PER_BIT cycles; expected bit is XOR-reduction of the data (even parity).
REQ-022 STOP: SHALL sample after CLKS_PER_BIT cycles; on the following cycle update data_o, par_err_o, frm_err_o, pulse valid_o for exactly one cycle, and enter IDLE.
REQ-023 Frame latency: valid_o SHALL assert CLKS_PER_BIT/2 + (N_DATA+2)*CLKS_PER_BIT + 1 cycles after rx_s first goes low.
REQ-024 Stop bit low SHALL set frm_err_o=1 and still deliver data; FSM returns to IDLE and waits for rx_s high->low before a new frame (no re-arm on a held-low line).
REQ-025 led_o SHALL show all-ones (blank) until the first frame, then ERR_CODE if par_err_o or frm_err_o, else OK_CODE, held until next frame.
REQ-026 Line changes during mid-bit only SHALL be ignored; only the sample instant matters.

Reset
REQ-027 rst_i SHALL, on the next clock edge, force FSM to IDLE, counters to 0, data_o=0, valid_o=0, par_err_o=0, frm_err_o=0, led_o=all-ones, synchronizer flops to 1.
REQ-028 Reset mid-frame SHALL discard the partial frame with no valid_o pulse.

Configuration
REQ-029 Macro PARITY_ODD_EN SHALL, when defined, make the expected parity bit the inverse of the data XOR (odd parity); when undefined, even parity per REQ-021.

Structure
REQ-030 A shared package SHALL hold the FSM state enumeration, blank display constant and default OK/ERR codes.
REQ-031 The sample-timing counter SHALL be a sub-module named bit_timer (load, count, mid/full-bit strobes).

Verification (CLKS_PER_BIT=16, N_DATA=8, even parity)
REQ-032 Frame 0x55, parity 0, stop 1 -> data_o=0x55, valid_o one cycle at 169 cycles after rx_s low, par_err_o=0, led_o=OK_CODE.
REQ-033 Frame 0x07, parity 0 (wrong) -> data_o=0x07, par_err_o=1, led_o=ERR_CODE; repeat with PARITY_ODD_EN defined -> par_err_o=0.
REQ-034 rx_i low for 4 cycles then high -> no valid_o, FSM back in IDLE, outputs unchanged.
REQ-035 Frame 0xA3, correct parity, stop 0 -> frm_err_o=1, par_err_o=0, valid_o pulses; no new frame until line high then low.
REQ-036 rst_i asserted during DATA bit 4 -> no valid_o, all outputs at reset values; next clean frame 0x3C received correctly.
REQ-037 Back-to-back frames 0x01, 0xFF with no idle gap -> two valid_o pulses, data_o 0x01 then 0xFF, no errors.
